// File: rtl/alu_issue_pkg.sv
`default_nettype none
// alu_issue_pkg: controller state encoding, instruction field positions and NZCV bit order.
// Shared by the ALU issue controller and its register file. Rev 1.0
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam int NW_BIT = 29;
  localparam int S_BIT  = 28;
  localparam int OP_HI  = 27;
  localparam int OP_LO  = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RA_HI  = 19;
  localparam int RA_LO  = 16;
  localparam int RS_HI  = 15;
  localparam int RS_LO  = 12;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  // The ALU never sees register indices; everything else (op, S, NW, immediates) passes through.
  function automatic logic [31:0] alu_inf_of(input logic [31:0] word);
    logic [31:0] masked;
    masked = word;
    masked[RD_HI:RS_LO] = '0;
    return masked;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_regfile.sv
`default_nettype none
// alu_issue_regfile: 16 x DW registers, one synchronous write port, two operand reads and a debug read.
// Register 0 is hardwired to zero on every read port. Rev 1.0
module alu_issue_regfile #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [3:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [3:0]    raddr_a_i,
  input  logic [3:0]    raddr_b_i,
  input  logic [3:0]    dbg_addr_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] regs_q [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 4'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == 4'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == 4'd0) ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == 4'd0) ? '0 : regs_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// alu_issue_ctrl: sequences one instruction at a time through a combinational ALU
// (IDLE -> ISSUE -> EXEC x ALU_LAT -> WB) with register-file operands and writeback. Rev 1.0
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DW      = 32,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          ld_en,
  input  logic [3:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [3:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_d,
  output logic [31:0]   alu_inf,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic [3:0]    flags,
  output logic          busy,
  output logic          done
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e        state_q;
  logic [31:0]   instr_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_d_q;
  logic [31:0]   alu_inf_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] r_q;
  logic [3:0]    nzcv_q;
  logic [3:0]    flags_q;
  logic          done_q;

  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  // Preload only owns the write port in IDLE; writeback only in WB, so they never collide.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if ((state_q == ST_IDLE) && ld_en) begin
      rf_we = 1'b1;
    end else if ((state_q == ST_WB) && !instr_q[NW_BIT]) begin
      rf_we    = 1'b1;
      rf_waddr = instr_q[RD_HI:RD_LO];
      rf_wdata = r_q;
    end
  end

  alu_issue_regfile #(.DW(DW)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (instr_q[RA_HI:RA_LO]),
    .raddr_b_i  (instr_q[RS_HI:RS_LO]),
    .dbg_addr_i (dbg_addr),
    .rdata_a_o  (rd_a),
    .rdata_b_o  (rd_b),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_d_q   <= '0;
      alu_inf_q <= '0;
      cnt_q     <= '0;
      r_q       <= '0;
      nzcv_q    <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && !ld_en) begin
            instr_q <= instr;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_a_q   <= rd_a;
          alu_d_q   <= rd_b;
          alu_inf_q <= alu_inf_of(instr_q);
          cnt_q     <= CNT_INIT;
          state_q   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            r_q           <= alu_r;
            nzcv_q[N_IDX] <= alu_n;
            nzcv_q[Z_IDX] <= alu_z;
            nzcv_q[C_IDX] <= alu_c;
            nzcv_q[V_IDX] <= alu_v;
            done_q        <= 1'b1;
            state_q       <= ST_WB;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WB: begin
          if (instr_q[S_BIT]) begin
            flags_q <= nzcv_q;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE) && !ld_en;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign alu_a       = alu_a_q;
  assign alu_d       = alu_d_q;
  assign alu_inf     = alu_inf_q;
  assign flags       = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// tb_alu_issue_ctrl: two controllers (ALU_LAT=1 and 3) share stimulus; a timing-level model
// predicts every output each cycle, and directed scenarios pin literal results. Rev 1.0
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       = 1'b1;
  logic [31:0] instr       = '0;
  logic        instr_valid = 1'b0;
  logic        ld_en       = 1'b0;
  logic [3:0]  ld_addr     = '0;
  logic [31:0] ld_data     = '0;
  logic [3:0]  dbg_addr    = '0;
  logic [31:0] prog_r      = '0;
  logic [3:0]  prog_nzcv   = '0;

  logic [1:0]       ready_w, busy_w, done_w;
  logic [1:0][31:0] dbg_w, alu_a_w, alu_d_w, alu_inf_w, alu_r_w;
  logic [1:0][3:0]  nzcv_w, flags_w;

  int checks = 0;
  int errors = 0;

  // Stub ALU: op 0 adds with real flags, op 1 returns programmed values, others scramble.
  function automatic logic [35:0] stub_f(input logic [31:0] a, input logic [31:0] d,
                                         input logic [31:0] inf, input logic [31:0] pr,
                                         input logic [3:0] pf);
    logic [32:0] sum;
    logic [31:0] r;
    logic [3:0]  f;
    case (inf[27:24])
      4'd0: begin
        sum = {1'b0, a} + {1'b0, d};
        r   = sum[31:0];
        f   = {r[31], (r == 32'd0), sum[32], (a[31] == d[31]) && (r[31] != a[31])};
      end
      4'd1: begin
        r = pr;
        f = pf;
      end
      default: begin
        r = a ^ {d[15:0], d[31:16]} ^ inf;
        f = inf[31:28] ^ a[3:0];
      end
    endcase
    return {r, f};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_stub
    assign {alu_r_w[g], nzcv_w[g]} = stub_f(alu_a_w[g], alu_d_w[g], alu_inf_w[g], prog_r, prog_nzcv);
  end

  alu_issue_ctrl #(.DW(32), .ALU_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(ready_w[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_w[0]),
    .alu_a(alu_a_w[0]), .alu_d(alu_d_w[0]), .alu_inf(alu_inf_w[0]), .alu_r(alu_r_w[0]),
    .alu_n(nzcv_w[0][3]), .alu_z(nzcv_w[0][2]), .alu_c(nzcv_w[0][1]), .alu_v(nzcv_w[0][0]),
    .flags(flags_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  alu_issue_ctrl #(.DW(32), .ALU_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(ready_w[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_w[1]),
    .alu_a(alu_a_w[1]), .alu_d(alu_d_w[1]), .alu_inf(alu_inf_w[1]), .alu_r(alu_r_w[1]),
    .alu_n(nzcv_w[1][3]), .alu_z(nzcv_w[1][2]), .alu_c(nzcv_w[1][1]), .alu_v(nzcv_w[1][0]),
    .flags(flags_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k counts edges since the accept edge; operands appear after edge 1, the result is
  // sampled at edge LAT+1 (done high for the following cycle) and committed at edge LAT+2.
  logic [31:0] m_regs [2][16];
  logic [31:0] m_instr [2], m_a [2], m_d [2], m_inf [2], m_r [2];
  logic [3:0]  m_nzcv [2], m_flags [2];
  logic        m_busy [2], m_done [2];
  int          m_k [2];

  task automatic model_step(input int i);
    int lat;
    logic [35:0] res;
    lat = (i == 0) ? 1 : 3;
    if (reset) begin
      for (int j = 0; j < 16; j++) m_regs[i][j] = '0;
      m_flags[i] = '0; m_a[i] = '0; m_d[i] = '0; m_inf[i] = '0;
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_k[i] = 0;
    end else if (!m_busy[i]) begin
      if (ld_en) begin
        if (ld_addr != 4'd0) m_regs[i][ld_addr] = ld_data;
      end else if (instr_valid) begin
        m_busy[i] = 1'b1; m_k[i] = 0; m_instr[i] = instr;
      end
    end else begin
      m_k[i]++;
      if (m_k[i] == 1) begin
        m_a[i]   = m_regs[i][m_instr[i][19:16]];
        m_d[i]   = m_regs[i][m_instr[i][15:12]];
        m_inf[i] = m_instr[i] & 32'hFF00_0FFF;
      end
      if (m_k[i] == lat + 1) begin
        res = stub_f(m_a[i], m_d[i], m_inf[i], prog_r, prog_nzcv);
        m_r[i] = res[35:4]; m_nzcv[i] = res[3:0]; m_done[i] = 1'b1;
      end else if (m_k[i] == lat + 2) begin
        m_done[i] = 1'b0; m_busy[i] = 1'b0;
        if (!m_instr[i][29] && m_instr[i][23:20] != 4'd0) m_regs[i][m_instr[i][23:20]] = m_r[i];
        if (m_instr[i][28]) m_flags[i] = m_nzcv[i];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), busy_w[i], m_busy[i]);
      chk($sformatf("done%0d", i), done_w[i], m_done[i]);
      chk($sformatf("ready%0d", i), ready_w[i], !m_busy[i] && !ld_en);
      chk($sformatf("alu_a%0d", i), alu_a_w[i], m_a[i]);
      chk($sformatf("alu_d%0d", i), alu_d_w[i], m_d[i]);
      chk($sformatf("alu_inf%0d", i), alu_inf_w[i], m_inf[i]);
      chk($sformatf("flags%0d", i), flags_w[i], m_flags[i]);
      chk($sformatf("dbg%0d", i), dbg_w[i], (dbg_addr == 4'd0) ? 32'd0 : m_regs[i][dbg_addr]);
    end
  end

  int          done_at [2];
  logic [31:0] a_first;
  int          stable_cnt;

  task automatic load(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk); ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(negedge clk); ld_en = 1'b0;
  endtask

  // Accepts on both instances at the same edge, then follows them until both are idle again.
  task automatic issue(input logic [31:0] w);
    logic [31:0] a3, d3, inf3;
    @(negedge clk); instr = w; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    done_at = '{-1, -1}; stable_cnt = 0; a3 = '0; d3 = '0; inf3 = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #2;
      if (n == 1) begin
        a_first = alu_a_w[0]; a3 = alu_a_w[1]; d3 = alu_d_w[1]; inf3 = alu_inf_w[1];
      end
      if (n <= 3 && busy_w[1] && !done_w[1] && alu_a_w[1] == a3 && alu_d_w[1] == d3
          && alu_inf_w[1] == inf3) stable_cnt++;
      for (int i = 0; i < 2; i++) if (done_w[i] && done_at[i] < 0) done_at[i] = n;
      if (done_at[0] >= 0 && done_at[1] >= 0 && busy_w == 2'b00) break;
    end
    chk("wb_seen_lat1", done_at[0] >= 0, 1'b1);
    chk("wb_seen_lat3", done_at[1] >= 0, 1'b1);
  endtask

  task automatic dbg_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk); dbg_addr = a; #1;
    chk({nm, "_lat1"}, dbg_w[0], exp);
    chk({nm, "_lat3"}, dbg_w[1], exp);
  endtask

  task automatic flags_chk(input string nm, input logic [3:0] exp);
    chk({nm, "_lat1"}, flags_w[0], exp);
    chk({nm, "_lat3"}, flags_w[1], exp);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) m_regs[i][j] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_ready", ready_w, 2'b11);
    chk("rst_busy", busy_w, 2'b00);
    flags_chk("rst_flags", 4'b0000);

    // 2 + 2 through the add stub; done opens LAT+1 edges after the accept edge.
    load(4'd1, 32'd2); load(4'd2, 32'd2);
    issue(32'h1031_2000);
    chk("t1_alu_a", a_first, 32'd2);
    chk("t1_done_lat1", done_at[0], 2);
    chk("t1_done_lat3", done_at[1], 4);
    chk("t1_stable3", stable_cnt, 3);
    chk("t1_inf3", alu_inf_w[1], 32'h1000_0000);
    chk("t1_alu_d", alu_d_w[0], 32'd2);
    dbg_chk("t1_r3", 4'd3, 32'd4);
    flags_chk("t1_flags", 4'b0000);

    // Compare: NW=1 S=1 leaves r3 alone but loads flags.
    prog_r = 32'hDEAD_BEEF; prog_nzcv = 4'b1011;
    issue(32'h3131_0000);
    dbg_chk("t3_r3", 4'd3, 32'd4);
    flags_chk("t3_flags", 4'b1011);

    // S=0: result written, flags keep 1011.
    prog_r = 32'd0; prog_nzcv = 4'b0100;
    issue(32'h0131_2000);
    dbg_chk("t2_r3", 4'd3, 32'd0);
    flags_chk("t2_flags", 4'b1011);

    // Writeback to r0 is discarded.
    prog_r = 32'hFFFF_FFFF;
    issue(32'h1101_2000);
    dbg_chk("t4_r0", 4'd0, 32'd0);
    flags_chk("t4_flags", 4'b0100);

    // Load and valid together: load wins, instruction taken one cycle later.
    @(negedge clk); ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'h55; instr = 32'h0061_2000; instr_valid = 1'b1;
    #1 chk("combo_ready", ready_w, 2'b00);
    @(posedge clk); #2 chk("combo_idle", busy_w, 2'b00);
    @(negedge clk); ld_en = 1'b0;
    #1 chk("combo_ready2", ready_w, 2'b11);
    @(posedge clk); #2 chk("combo_accept", busy_w, 2'b11);
    @(negedge clk); instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    dbg_chk("combo_r5", 4'd5, 32'h55);
    dbg_chk("combo_r6", 4'd6, 32'd4);

    // Dependent chain r3=r1+r2, r4=r3+r1.
    issue(32'h0031_2000);
    issue(32'h0043_1000);
    chk("chain_alu_a", a_first, 32'd4);
    dbg_chk("chain_r4", 4'd4, 32'd6);

    // Reset while both are in EXEC: no done, everything cleared.
    @(negedge clk); instr = 32'h1031_2000; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    chk("rst_exec_done", done_w, 2'b00);
    chk("rst_exec_busy", busy_w, 2'b00);
    @(negedge clk); reset = 1'b0;
    #1 chk("rst_exec_ready", ready_w, 2'b11);
    flags_chk("rst_exec_flags", 4'b0000);
    for (int a = 1; a <= 6; a++) dbg_chk("rst_exec_reg", 4'(a), 32'd0);

    // Random traffic; the per-cycle model comparison does the checking.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 199) == 0);
      ld_en       = ($urandom_range(0, 4) == 0);
      ld_addr     = 4'($urandom);
      ld_data     = $urandom;
      instr_valid = ($urandom_range(0, 2) == 0);
      instr       = $urandom;
      dbg_addr    = 4'($urandom);
      prog_r      = $urandom;
      prog_nzcv   = 4'($urandom);
    end
    @(negedge clk); reset = 1'b0; ld_en = 1'b0; instr_valid = 1'b0;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/instruction interface. Accepts 32-bit instruction words over a valid/ready handshake and reads both operands from an internal 16x32 register file.
- Drives the ALU's a, d and inf inputs, samples r and the n/z/c/v flags, then writes the result back and updates a status flag register.
- Sits between the fetch/test front end and the combinational ALU, turning it into a sequenced execute stage.

Parameters:
- DW, 32, datapath width; matches the ALU's a, d, r and inf width.
- ALU_LAT, 1, cycles operands are held before r and flags are sampled; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  controller can accept an instruction
- ld_en  in  1  register preload strobe
- ld_addr  in  4  preload register index
- ld_data  in  DW  preload value
- dbg_addr  in  4  debug read index
- dbg_data  out  DW  combinational read of regfile[dbg_addr]
- alu_a  out  DW  operand A to the ALU
- alu_d  out  DW  operand D to the ALU
- alu_inf  out  32  instruction field to the ALU
- alu_r  in  DW  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags
- flags  out  4  {N,Z,C,V} status register
- busy  out  1  an instruction is in flight
- done  out  1  one-cycle pulse on writeback

Behaviour:
- Reset (synchronous, active-high), takes effect at the next clk edge:
  - All 16 registers, alu_a, alu_d, alu_inf and flags go to 0; done=0; busy=0; state IDLE.
  - Aborts any in-flight instruction; no writeback and no done pulse.
- Instruction fields:
  - [28] S: update flags.
  - [29] NW: no writeback (compare).
  - [27:24] op.
  - [23:20] rd; [19:16] ra; [15:12] rs.
  - alu_inf = instr with bits [23:12] forced to 0. All other bits pass through unchanged.
- Register 0 reads as 0; writes to r0 (load or writeback) are discarded.
- States: IDLE, ISSUE, EXEC, WB.
- IDLE:
  - instr_ready = !ld_en.
  - ld_en writes regfile[ld_addr] at the edge.
  - On an accept (instr_valid & instr_ready) at edge T, latch instr; next state ISSUE.
  - ld_en is ignored in all non-IDLE states.
- ISSUE (one cycle):
  - Register alu_a=reg[ra], alu_d=reg[rs], alu_inf.
  - Load an exec counter with ALU_LAT-1; next state EXEC.
- EXEC:
  - alu_a, alu_d and alu_inf are held stable.
  - The counter decrements each cycle.
  - When it reaches 0, latch alu_r and the four flags; next state WB.
- WB (one cycle):
  - done=1.
  - If !NW, reg[rd] is written with the latched r.
  - If S, flags is written with the latched {n,z,c,v}; otherwise flags holds.
  - Next state IDLE.
- Latency: accept at edge T gives the WB cycle T+ALU_LAT+2 and the write visible in the cycle after. Throughput is one instruction per ALU_LAT+3 cycles.
- busy = (state != IDLE).
- alu_* outputs hold their last values in IDLE.
- A back-to-back dependent instruction (rd of N equals ra of N+1) reads the written value; there is no hazard, because ISSUE follows WB by at least one IDLE cycle.
- dbg_data is combinational. A same-cycle write returns the old value.
- Unknown op values are passed to the ALU unchanged; the controller does not decode op.

Decomposition:
- Package alu_issue_pkg holds:
  - the state enum;
  - field-position constants (S_BIT=28, NW_BIT=29, OP, RD, RA and RS slice bounds);
  - the NZCV bit-order constants.
- One natural sub-module: alu_issue_regfile (16xDW, one synchronous write port, two combinational read ports plus the debug read, r0 hardwired to zero). The write mux (load vs writeback) stays in the parent.

Test Plan:
The bench uses a stub ALU responder that returns programmed r/nzcv values.
- Preload r1=2, r2=2. Issue instr 0x1031_2000 (S=1, rd=3, ra=1, rs=2); stub returns r=4, nzcv=0000. Required: alu_a=2, alu_d=2, alu_inf=0x1000_0000; done 3 cycles after accept (ALU_LAT=1); r3=4; flags=0000.
- Issue with S=0. Stub returns r=0, nzcv=0100. Required: rd written 0; flags unchanged.
- Issue NW=1, S=1 (0x3000_0000 | ra=1). Stub returns nzcv=1011. Required: no register changes; flags=1011.
- rd=0 with stub r=0xFFFF_FFFF. Required: dbg read of r0=0. Also: ld_en and instr_valid asserted together in IDLE. Required: load completes, instr_ready=0 that cycle, instruction accepted the next cycle.
- ALU_LAT=3. Required: alu_a, alu_d and alu_inf stable for 3 EXEC cycles; done at accept+5. Also: assert reset during EXEC. Required: no done pulse, all registers 0, instr_ready=1 the next cycle.
- Back-to-back dependent chain r3=r1+r2 then r4=r3+r1, with the stub as an adder. Required: second alu_a=4, r4=6.
